// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - register file with bypassed reads and pending-write scoreboard
// Per-register counters let decode stall on operands with outstanding writes.
module gpr_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int PEND_MAX = 3,
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int CNT_W   = $clog2(PEND_MAX + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [ADDR_W-1:0]       i_wr_addr,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic [31:0]             i_wr_pc,
  input  logic [NRD*ADDR_W-1:0]   i_rd_addr,
  output logic [NRD*DATA_W-1:0]   o_rd_data,
  output logic [NRD-1:0]          o_rd_busy,
  input  logic                    i_alloc_en,
  input  logic [ADDR_W-1:0]       i_alloc_addr,
  output logic                    o_alloc_ready,
  output logic                    o_trace_valid,
  output logic [ADDR_W-1:0]       o_trace_addr,
  output logic [DATA_W-1:0]       o_trace_data,
  output logic [31:0]             o_trace_pc,
  output logic                    o_sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PEND_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_mem [NREG];
  logic [CNT_W-1:0]  r_cnt [NREG];
  logic              r_sb_err;
  logic              r_trace_valid;
  logic [ADDR_W-1:0] r_trace_addr;
  logic [DATA_W-1:0] r_trace_data;
  logic [31:0]       r_trace_pc;

  logic              w_wr_elig;
  logic              w_alloc_elig;
  logic [CNT_W-1:0]  w_wr_cnt;
  logic              w_dec;
  logic              w_inc;
  logic              w_underflow;
  logic              w_overflow;
  logic              w_same;

  assign w_wr_elig     = i_wr_en && !((ZERO_R0 != 0) && (i_wr_addr == '0));
  assign w_alloc_elig  = !((ZERO_R0 != 0) && (i_alloc_addr == '0));
  assign w_wr_cnt      = r_cnt[i_wr_addr];
  assign w_dec         = w_wr_elig && (w_wr_cnt != '0);
  assign w_underflow   = w_wr_elig && (w_wr_cnt == '0);
  // Conservative: a same-cycle write to alloc_addr is not credited here.
  assign o_alloc_ready = r_cnt[i_alloc_addr] < CNT_MAX;
  assign w_inc         = i_alloc_en && o_alloc_ready && w_alloc_elig;
  assign w_overflow    = i_alloc_en && !o_alloc_ready;
  assign w_same        = w_inc && w_dec && (i_alloc_addr == i_wr_addr);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_zero;
    logic              w_byp;
    logic              w_sub;
    assign w_a    = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_R0 != 0) && (w_a == '0);
    assign w_byp  = (BYPASS != 0) && i_wr_en && (w_a == i_wr_addr);
    assign w_sub  = w_dec && (i_wr_addr == w_a);
    assign o_rd_data[k*DATA_W +: DATA_W] = w_zero ? '0 : (w_byp ? i_wr_data : r_mem[w_a]);
    assign o_rd_busy[k] = (r_cnt[w_a] - (w_sub ? CNT_ONE : '0)) != '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_sb_err      <= 1'b0;
      r_trace_valid <= 1'b0;
      r_trace_addr  <= '0;
      r_trace_data  <= '0;
      r_trace_pc    <= '0;
    end else begin
      if (w_wr_elig) r_mem[i_wr_addr] <= i_wr_data;
      if (!w_same) begin
        if (w_inc) r_cnt[i_alloc_addr] <= r_cnt[i_alloc_addr] + CNT_ONE;
        if (w_dec) r_cnt[i_wr_addr] <= w_wr_cnt - CNT_ONE;
      end
      if (w_overflow || w_underflow) r_sb_err <= 1'b1;
      r_trace_valid <= w_wr_elig;
      if (w_wr_elig) begin
        r_trace_addr <= i_wr_addr;
        r_trace_data <= i_wr_data;
        r_trace_pc   <= i_wr_pc;
      end
    end
  end

  assign o_sb_err      = r_sb_err;
  assign o_trace_valid = r_trace_valid;
  assign o_trace_addr  = r_trace_addr;
  assign o_trace_data  = r_trace_data;
  assign o_trace_pc    = r_trace_pc;

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb/tb_gpr_file_sb.sv - directed-vector bench for gpr_file_sb
// Instance a uses default parameters; instance b is 4-port, 16-bit, no bypass.
module tb_gpr_file_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_wr_en, a_alloc_en;
  logic [4:0]  a_wr_addr, a_alloc_addr;
  logic [31:0] a_wr_data, a_wr_pc;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_alloc_ready, a_trace_valid, a_sb_err;
  logic [4:0]  a_trace_addr;
  logic [31:0] a_trace_data, a_trace_pc;

  logic        b_wr_en, b_alloc_en;
  logic [3:0]  b_wr_addr, b_alloc_addr;
  logic [15:0] b_wr_data;
  logic [31:0] b_wr_pc;
  logic [15:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_alloc_ready, b_trace_valid, b_sb_err;
  logic [3:0]  b_trace_addr;
  logic [15:0] b_trace_data;
  logic [31:0] b_trace_pc;

  gpr_file_sb u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data), .i_wr_pc(a_wr_pc),
    .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data), .o_rd_busy(a_rd_busy),
    .i_alloc_en(a_alloc_en), .i_alloc_addr(a_alloc_addr), .o_alloc_ready(a_alloc_ready),
    .o_trace_valid(a_trace_valid), .o_trace_addr(a_trace_addr),
    .o_trace_data(a_trace_data), .o_trace_pc(a_trace_pc), .o_sb_err(a_sb_err)
  );

  gpr_file_sb #(.DATA_W(16), .NREG(16), .NRD(4), .BYPASS(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .i_wr_pc(b_wr_pc),
    .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data), .o_rd_busy(b_rd_busy),
    .i_alloc_en(b_alloc_en), .i_alloc_addr(b_alloc_addr), .o_alloc_ready(b_alloc_ready),
    .o_trace_valid(b_trace_valid), .o_trace_addr(b_trace_addr),
    .o_trace_data(b_trace_data), .o_trace_pc(b_trace_pc), .o_sb_err(b_sb_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_busy;
    exp_busy = 3'b011;
    rst_n = 1'b0;
    a_wr_en = 0; a_alloc_en = 0; a_wr_addr = 0; a_alloc_addr = 0;
    a_wr_data = 0; a_wr_pc = 0; a_rd_addr = 0;
    b_wr_en = 0; b_alloc_en = 0; b_wr_addr = 0; b_alloc_addr = 0;
    b_wr_data = 0; b_wr_pc = 0; b_rd_addr = 0;

    @(negedge clk);
    check("rst_alloc_ready", 64'(a_alloc_ready), 64'd1);
    check("rst_rd_data", a_rd_data, 64'd0);
    check("rst_rd_busy", 64'(a_rd_busy), 64'd0);
    check("rst_sb_err", 64'(a_sb_err), 64'd0);
    check("rst_trace_valid", 64'(a_trace_valid), 64'd0);
    step();
    rst_n = 1'b1;

    // r5: allocate, then write with same-cycle bypass
    a_alloc_en = 1; a_alloc_addr = 5;
    step();
    a_alloc_en = 0;
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'hDEADBEEF; a_wr_pc = 32'h3000;
    a_rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    check("r5_bypass", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
    check("r5_busy_wr", 64'(a_rd_busy[0]), 64'd0);
    step();
    a_wr_en = 0;
    #1;
    check("r5_trace_valid", 64'(a_trace_valid), 64'd1);
    check("r5_trace_addr", 64'(a_trace_addr), 64'd5);
    check("r5_trace_data", 64'(a_trace_data), 64'hDEADBEEF);
    check("r5_trace_pc", 64'(a_trace_pc), 64'h3000);
    check("r5_stored", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
    check("r5_sb_err", 64'(a_sb_err), 64'd0);

    // r0: write and alloc are ignored
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'h1234; a_wr_pc = 32'h3004;
    a_alloc_en = 1; a_alloc_addr = 0;
    a_rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    check("r0_rd", 64'(a_rd_data[63:32]), 64'd0);
    check("r0_busy", 64'(a_rd_busy[1]), 64'd0);
    step();
    a_wr_en = 0; a_alloc_en = 0;
    #1;
    check("r0_trace_valid", 64'(a_trace_valid), 64'd0);
    check("r0_trace_hold", 64'(a_trace_data), 64'hDEADBEEF);
    check("r0_sb_err", 64'(a_sb_err), 64'd0);
    check("r0_rd_after", 64'(a_rd_data[63:32]), 64'd0);
    check("r0_busy_after", 64'(a_rd_busy[1]), 64'd0);

    // r7: fill to PEND_MAX, overflow, then drain
    a_alloc_en = 1; a_alloc_addr = 7;
    repeat (3) step();
    check("r7_ready_full", 64'(a_alloc_ready), 64'd0);
    check("r7_sb_err_pre", 64'(a_sb_err), 64'd0);
    step();
    a_alloc_en = 0;
    #1;
    check("r7_overflow_err", 64'(a_sb_err), 64'd1);
    a_rd_addr = {5'd0, 5'd7};
    for (int i = 0; i < 3; i++) begin
      a_wr_en = 1; a_wr_addr = 7; a_wr_data = 32'(i);
      @(negedge clk);
      check($sformatf("r7_busy_wr%0d", i), 64'(a_rd_busy[0]), 64'(exp_busy[i]));
      step();
    end
    a_wr_en = 0;
    #1;
    check("r7_ready_drained", 64'(a_alloc_ready), 64'd1);
    check("r7_busy_drained", 64'(a_rd_busy[0]), 64'd0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_sb_err", 64'(a_sb_err), 64'd0);

    // r9: simultaneous alloc and write from count 1
    a_alloc_en = 1; a_alloc_addr = 9;
    step();
    a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'h99;
    a_rd_addr = {5'd0, 5'd9};
    @(negedge clk);
    check("r9_busy_same", 64'(a_rd_busy[0]), 64'd0);
    check("r9_bypass", 64'(a_rd_data[31:0]), 64'h99);
    step();
    a_wr_en = 0; a_alloc_en = 0;
    #1;
    check("r9_busy_after", 64'(a_rd_busy[0]), 64'd1);
    check("r9_sb_err", 64'(a_sb_err), 64'd0);

    // r3: underflow write, then asynchronous reset mid-cycle
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'hCAFE; a_wr_pc = 32'h4000;
    a_rd_addr = {5'd3, 5'd9};
    step();
    a_wr_en = 0;
    #1;
    check("r3_stored", 64'(a_rd_data[63:32]), 64'hCAFE);
    check("r3_underflow_err", 64'(a_sb_err), 64'd1);
    check("r3_trace_valid", 64'(a_trace_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_sb_err", 64'(a_sb_err), 64'd0);
    check("async_r3", 64'(a_rd_data[63:32]), 64'd0);
    check("async_trace_valid", 64'(a_trace_valid), 64'd0);
    check("async_trace_data", 64'(a_trace_data), 64'd0);
    check("async_trace_pc", 64'(a_trace_pc), 64'd0);
    check("async_busy_r9", 64'(a_rd_busy[0]), 64'd0);
    step();
    rst_n = 1'b1;

    // instance b: four ports on r2, no bypass
    b_rd_addr = {4{4'd2}};
    b_wr_en = 1; b_wr_addr = 2; b_wr_data = 16'h1111;
    step();
    b_wr_data = 16'hA5A5;
    @(negedge clk);
    check("b_old_data", b_rd_data, {4{16'h1111}});
    step();
    b_wr_en = 0;
    #1;
    check("b_new_data", b_rd_data, {4{16'hA5A5}});
    check("b_trace_data", 64'(b_trace_data), 64'hA5A5);
    check("b_trace_addr", 64'(b_trace_addr), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file with a per-register pending-write scoreboard, for the pipelined datapath. It provides NRD combinational read ports with same-cycle write-to-read bypass and one synchronous write port. Per-register counters track outstanding writes so decode can stall on busy operands. A registered write-trace port replaces simulation-only printing.

## Interface
- DATA_W, 32, register width in bits
- NREG, 32, number of registers; ADDR_W = clog2(NREG)
- NRD, 2, number of read ports (1..4)
- PEND_MAX, 3, maximum outstanding writes per register (1..7); CNT_W = clog2(PEND_MAX+1)
- ZERO_R0, 1, 1: register 0 reads 0 and ignores writes and allocations
- BYPASS, 1, 1: a read of the register being written this cycle returns wr_data
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write register
- wr_data  in  DATA_W  write data
- wr_pc  in  32  PC of the writing instruction, for trace only
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, packed the same way
- rd_busy  out  NRD  1 when the port-k register has a pending count ≠ 0 after this cycle's write clear
- alloc_en  in  1  decode issues an instruction that will write alloc_addr
- alloc_addr  in  ADDR_W  destination being allocated
- alloc_ready  out  1  count[alloc_addr] < PEND_MAX
- trace_valid  out  1  registered: a write committed last cycle
- trace_addr  out  ADDR_W  registered write address
- trace_data  out  DATA_W  registered written data
- trace_pc  out  32  registered wr_pc
- sb_err  out  1  sticky: overflow or underflow error

## Operation
- Storage: NREG x DATA_W, written at posedge clk when wr_en=1 and not (ZERO_R0 and wr_addr=0).
- Read k: if ZERO_R0 and addr=0, return 0; else if BYPASS, wr_en and addr=wr_addr, return wr_data; else return the stored value. Reads are purely combinational.
- Scoreboard: count[r] of CNT_W bits per register. At each edge, inc = alloc_en & alloc_ready & eligible(alloc_addr), and dec = wr_en & eligible(wr_addr) & count[wr_addr]≠0. "Eligible" excludes r0 when ZERO_R0=1.
- Same register with inc and dec: count unchanged. Different registers: each updates independently.
- Overflow: alloc_en=1 with alloc_ready=0 makes no count change and sets sb_err.
- Underflow: an eligible write with count[wr_addr]=0 still writes the data, leaves the count at 0, and sets sb_err.
- sb_err clears only on reset.
- rd_busy[k] = (count[addr_k] − (dec and wr_addr=addr_k)) ≠ 0. It is always 0 for r0 when ZERO_R0=1.
- alloc_ready uses the current count, without crediting a same-cycle dec. This is deliberately conservative.
- Trace: on every edge, trace_valid <= wr_en & eligible(wr_addr). The trace fields load only when that bit is 1; otherwise they hold.

## Timing
- Reset asserted (reset=0), effective immediately and asynchronously:
  - all registers, counts, sb_err, trace_valid and trace fields go to 0;
  - alloc_ready=1; rd_data=0 and rd_busy=0, unless bypass is active.
- Reset deasserts synchronously to clk. The first edge with reset=1 may write or allocate.
- Reset mid-operation discards all pending counts. Writes from instructions in flight after release cause underflow (sb_err). The pipeline flush is the owner's responsibility.
- Write latency: 1 edge to storage, 0 cycles via bypass. With BYPASS=0, new data is visible the cycle after the edge.
- Trace latency: exactly 1 cycle after the write edge.
- Multiple read ports may address the same register, each receiving identical data.

## Test plan
- Reset, then write r5=0xDEADBEEF with wr_pc=0x3000. Required: rd port0 addr 5 bypasses 0xDEADBEEF in the same cycle. Next cycle: trace_valid=1, trace_addr=5, trace_data=0xDEADBEEF, trace_pc=0x3000.
- Write r0=0x1234 and alloc r0. Required: rd r0=0, rd_busy=0, trace_valid=0, sb_err=0.
- Alloc r7 three times (PEND_MAX=3). Required: alloc_ready=0, and a 4th alloc sets sb_err=1 with the count staying 3. Then three writes to r7: rd_busy goes 1,1,0 during the write cycles, then alloc_ready=1.
- Same edge alloc r9 and write r9, starting from count 1. Required: count stays 1, rd_busy(r9)=0 during that cycle, and 1 afterwards.
- Write r3 with count 0. Required: data stored, sb_err=1. Then hold reset low mid-cycle: sb_err, r3 and trace clear immediately without a clock edge.
- NRD=4, DATA_W=16, NREG=16, BYPASS=0. Required: all four ports read r2 after writing 0xA5A5, showing old data in the write cycle and 0xA5A5 on all ports the next cycle.
